msrv32_pc_gen: RTL and testbench
================================

Name: msrv32_pc_gen

Overview:
- Parametrised next-generation PC unit for the msrv32 fetch stage.
- Owns the architectural fetch-PC register, which the previous pc_mux left to the caller.
- Adds a redirect-hold buffer so that a branch, trap or return that arrives while the AHB instruction port is stalled is never lost.
- Supports configurable XLEN, boot address and optional 16-bit (C-extension) instruction alignment. Sits between the branch/trap units and the instruction AHB master.

Parameters:
- XLEN, 32: address/PC width.
- BOOT_ADDRESS, {XLEN{1'b0}}: PC loaded on reset and selected by pc_src_in=00.
- C_EXT, 0: 0 = targets must be 4-byte aligned; 1 = 2-byte aligned targets are legal.

Ports:
- ms_riscv32_mp_clk_in  in  1  core clock
- rst_in  in  1  synchronous active-high reset
- ahb_ready_in  in  1  instruction port accepts the address this cycle
- pc_src_in  in  2  00 boot, 01 epc, 10 trap, 11 sequential/branch
- branch_taken_in  in  1  jump/branch resolved taken
- iaddr_in  in  XLEN-1  branch target bits [XLEN-1:1]
- epc_in  in  XLEN  mret return address
- trap_address_in  in  XLEN  trap vector
- pc_mux_out  out  XLEN  combinational next-PC selection
- iaddr_out  out  XLEN  registered fetch address (current PC)
- pc_plus_4_out  out  XLEN  iaddr_out + 4, modulo 2^XLEN
- misaligned_instr_logic_out  out  1  taken branch target misaligned
- redirect_pending_out  out  1  a buffered redirect awaits ahb_ready_in
- fetch_valid_out  out  1  iaddr_out is a live fetch address

Behaviour:
- Sequential core: an FSM plus registers iaddr_q, pend_valid_q and pend_addr_q. iaddr_out = iaddr_q.
- next_pc is {iaddr_in,1'b0} when branch_taken_in is set, otherwise pc_plus_4_out.
- pc_mux_out selection by pc_src_in:
  - 00: BOOT_ADDRESS
  - 01: epc_in
  - 10: trap_address_in
  - 11: next_pc
- redirect = (pc_src_in != 2'b11) | branch_taken_in.
- misaligned_instr_logic_out = branch_taken_in & (pc_src_in==11) & (C_EXT ? 0 : next_pc[1]).
  - Purely combinational.
  - The target is still loaded; the trap unit redirects on the following cycle.
- FSM states:
  - RESET_S
    - Entered whenever rst_in=1, from any state.
    - Outputs: iaddr_q=BOOT_ADDRESS, pend_valid_q=0, pend_addr_q=0, fetch_valid_out=0.
    - Leaves for RUN_S on the first clock with rst_in=0. iaddr_q stays at BOOT_ADDRESS, giving a one-cycle bubble.
  - RUN_S, fetch_valid_out=1:
    - ahb_ready_in=1: iaddr_q <= pc_mux_out.
    - ahb_ready_in=0 and redirect: pend_addr_q <= pc_mux_out, pend_valid_q <= 1, go to HOLD_S, iaddr_q holds.
    - ahb_ready_in=0, no redirect: all registers hold.
  - HOLD_S, fetch_valid_out=0 (the held address is stale):
    - ahb_ready_in=0 and a new redirect: pend_addr_q overwritten with the new pc_mux_out (latest redirect wins).
    - ahb_ready_in=1 and a new redirect in the same cycle: iaddr_q <= pc_mux_out, pending entry discarded.
    - ahb_ready_in=1, no redirect: iaddr_q <= pend_addr_q.
    - Both ready cases clear pend_valid_q and return to RUN_S.
- redirect_pending_out = pend_valid_q.
- Arithmetic: all additions are unsigned XLEN-bit. Wrap from {XLEN{1}}-3 to 0 is legal and silent.
- Reset has priority over all inputs. rst_in asserted in HOLD_S drops the pending redirect.
- Outputs are defined in every cycle. No X may propagate from pend_addr_q when pend_valid_q=0.

Decomposition:
- Shared package msrv32_pkg holds:
  - PC_SRC_BOOT/EPC/TRAP/NEXT 2-bit constants
  - FSM state encodings RESET_S=2'd0, RUN_S=2'd1, HOLD_S=2'd2
  - XLEN default
- One natural sub-module: msrv32_pc_sel, the combinational next_pc and pc_mux_out selection plus misalignment check, parametrised on XLEN/BOOT_ADDRESS/C_EXT. The FSM and registers stay in the top.

Test Plan:
- Reset release, BOOT_ADDRESS=32'h0000_1000, pc_src=11, ready=1:
  - Cycle 0: iaddr=1000, fetch_valid=0.
  - Then 1000 (valid=1), 1004, 1008.
- Branch stall: iaddr=0x20, branch_taken=1, iaddr_in→target 0x80, ready=0 for 3 cycles:
  - redirect_pending=1, fetch_valid=0, iaddr holds 0x20.
  - On ready=1, iaddr=0x80, pending=0.
- Double redirect in HOLD: pending 0x80, then pc_src=10 with trap_address=0x100 while ready=0 → iaddr becomes 0x100 on ready, never 0x80.
- Misalignment: branch target 0x82, C_EXT=0 → misaligned_instr_logic_out=1 in the same cycle. With C_EXT=1 → 0, and iaddr=0x82.
- Wrap: iaddr=32'hFFFF_FFFC, sequential, ready=1 → pc_plus_4_out=0, next iaddr=0.
- Reset in HOLD: pending 0x80, rst_in=1 for 1 cycle → iaddr=BOOT_ADDRESS, pending=0, fetch_valid=0, and 0x80 is never issued.

Source files
------------

// File: rtl/msrv32_pkg.sv
// Shared constants for the msrv32 fetch-PC unit: PC source codes, FSM encodings, XLEN default.
// No logic, no latency, no flow control.
package msrv32_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [1:0] PC_SRC_BOOT = 2'b00;
  localparam logic [1:0] PC_SRC_EPC  = 2'b01;
  localparam logic [1:0] PC_SRC_TRAP = 2'b10;
  localparam logic [1:0] PC_SRC_NEXT = 2'b11;

  typedef enum logic [1:0] {
    RESET_S = 2'd0,
    RUN_S   = 2'd1,
    HOLD_S  = 2'd2
  } pc_state_e;

endpackage

// File: rtl/msrv32_pc_sel.sv
// Next-PC selection, redirect detection and branch-target misalignment check.
// Purely combinational (zero latency); no backpressure of its own.
module msrv32_pc_sel
  import msrv32_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] BOOT_ADDRESS = {XLEN{1'b0}},
  parameter int              C_EXT        = 0
) (
  input  logic [1:0]      pc_src,
  input  logic            branch_taken,
  input  logic [XLEN-2:0] iaddr_tgt,
  input  logic [XLEN-1:0] epc,
  input  logic [XLEN-1:0] trap_address,
  input  logic [XLEN-1:0] pc_plus_4,
  output logic [XLEN-1:0] pc_mux,
  output logic            misaligned,
  output logic            redirect
);

  logic [XLEN-1:0] next_pc;

  assign next_pc = branch_taken ? {iaddr_tgt, 1'b0} : pc_plus_4;

  always_comb begin
    pc_mux = next_pc;
    case (pc_src)
      PC_SRC_BOOT: pc_mux = BOOT_ADDRESS;
      PC_SRC_EPC:  pc_mux = epc;
      PC_SRC_TRAP: pc_mux = trap_address;
      default:     pc_mux = next_pc;
    endcase
  end

  assign redirect = (pc_src != PC_SRC_NEXT) | branch_taken;

  // With compressed instructions any halfword target is legal.
  assign misaligned = branch_taken & (pc_src == PC_SRC_NEXT) &
                      ((C_EXT != 0) ? 1'b0 : next_pc[1]);

endmodule

// File: rtl/msrv32_pc_gen.sv
// Fetch-PC register with a one-entry redirect-hold buffer; iaddr_out updates one cycle after selection.
// When ahb_ready_in is low the PC holds and a redirect is parked (latest wins) until the port accepts.
module msrv32_pc_gen
  import msrv32_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] BOOT_ADDRESS = {XLEN{1'b0}},
  parameter int              C_EXT        = 0
) (
  input  logic            ms_riscv32_mp_clk_in,
  input  logic            rst_in,
  input  logic            ahb_ready_in,
  input  logic [1:0]      pc_src_in,
  input  logic            branch_taken_in,
  input  logic [XLEN-2:0] iaddr_in,
  input  logic [XLEN-1:0] epc_in,
  input  logic [XLEN-1:0] trap_address_in,
  output logic [XLEN-1:0] pc_mux_out,
  output logic [XLEN-1:0] iaddr_out,
  output logic [XLEN-1:0] pc_plus_4_out,
  output logic            misaligned_instr_logic_out,
  output logic            redirect_pending_out,
  output logic            fetch_valid_out
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] iaddr_q;
  logic [XLEN-1:0] pend_addr_q;
  logic            pend_valid_q;
  logic            redirect;

  assign pc_plus_4_out = iaddr_q + {{(XLEN-3){1'b0}}, 3'd4};

  msrv32_pc_sel #(
    .XLEN         (XLEN),
    .BOOT_ADDRESS (BOOT_ADDRESS),
    .C_EXT        (C_EXT)
  ) u_pc_sel (
    .pc_src       (pc_src_in),
    .branch_taken (branch_taken_in),
    .iaddr_tgt    (iaddr_in),
    .epc          (epc_in),
    .trap_address (trap_address_in),
    .pc_plus_4    (pc_plus_4_out),
    .pc_mux       (pc_mux_out),
    .misaligned   (misaligned_instr_logic_out),
    .redirect     (redirect)
  );

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (rst_in) state_q <= RESET_S;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET_S: state_d = RUN_S;
      RUN_S:   if (!ahb_ready_in && redirect) state_d = HOLD_S;
      HOLD_S:  if (ahb_ready_in) state_d = RUN_S;
      default: state_d = RESET_S;
    endcase
  end

  // In HOLD_S the registered PC is stale until the parked redirect is issued.
  always_comb begin
    fetch_valid_out = (state_q == RUN_S);
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (rst_in) begin
      iaddr_q      <= BOOT_ADDRESS;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
    end else begin
      case (state_q)
        RUN_S: begin
          if (ahb_ready_in) begin
            iaddr_q <= pc_mux_out;
          end else if (redirect) begin
            pend_addr_q  <= pc_mux_out;
            pend_valid_q <= 1'b1;
          end
        end
        HOLD_S: begin
          if (ahb_ready_in) begin
            // A fresh redirect in the release cycle supersedes the parked one.
            iaddr_q      <= redirect ? pc_mux_out : pend_addr_q;
            pend_valid_q <= 1'b0;
          end else if (redirect) begin
            pend_addr_q <= pc_mux_out;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign iaddr_out            = iaddr_q;
  assign redirect_pending_out = pend_valid_q;

endmodule

// File: tb/tb_msrv32_pc_gen.sv
// Directed bench for msrv32_pc_gen: two instances (C_EXT=0/1) share stimulus and are checked
// every cycle against a transaction-level PC model plus hand-computed literal expectations.
module tb_msrv32_pc_gen;

  localparam logic [31:0] BOOT = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        ahb_ready_in;
  logic [1:0]  pc_src_in;
  logic        branch_taken_in;
  logic [30:0] iaddr_in;
  logic [31:0] epc_in;
  logic [31:0] trap_address_in;

  logic [31:0] pc_mux_a, iaddr_a, pp4_a;
  logic        mis_a, pend_a, fv_a;
  logic [31:0] pc_mux_c, iaddr_c, pp4_c;
  logic        mis_c, pend_c, fv_c;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  msrv32_pc_gen #(.XLEN(32), .BOOT_ADDRESS(BOOT), .C_EXT(0)) dut (
    .ms_riscv32_mp_clk_in       (clk),
    .rst_in                     (rst_in),
    .ahb_ready_in               (ahb_ready_in),
    .pc_src_in                  (pc_src_in),
    .branch_taken_in            (branch_taken_in),
    .iaddr_in                   (iaddr_in),
    .epc_in                     (epc_in),
    .trap_address_in            (trap_address_in),
    .pc_mux_out                 (pc_mux_a),
    .iaddr_out                  (iaddr_a),
    .pc_plus_4_out              (pp4_a),
    .misaligned_instr_logic_out (mis_a),
    .redirect_pending_out       (pend_a),
    .fetch_valid_out            (fv_a)
  );

  msrv32_pc_gen #(.XLEN(32), .BOOT_ADDRESS(BOOT), .C_EXT(1)) dut_c (
    .ms_riscv32_mp_clk_in       (clk),
    .rst_in                     (rst_in),
    .ahb_ready_in               (ahb_ready_in),
    .pc_src_in                  (pc_src_in),
    .branch_taken_in            (branch_taken_in),
    .iaddr_in                   (iaddr_in),
    .epc_in                     (epc_in),
    .trap_address_in            (trap_address_in),
    .pc_mux_out                 (pc_mux_c),
    .iaddr_out                  (iaddr_c),
    .pc_plus_4_out              (pp4_c),
    .misaligned_instr_logic_out (mis_c),
    .redirect_pending_out       (pend_c),
    .fetch_valid_out            (fv_c)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the architectural PC, whether we are still coming out of reset,
  // and at most one parked redirect target.
  logic [31:0] m_pc;
  bit          m_booting;
  bit          m_parked;
  logic [31:0] m_park_addr;

  function automatic logic [31:0] m_target();
    if (pc_src_in == 2'b00)      return BOOT;
    else if (pc_src_in == 2'b01) return epc_in;
    else if (pc_src_in == 2'b10) return trap_address_in;
    else if (branch_taken_in)    return {iaddr_in, 1'b0};
    else                         return m_pc + 32'd4;
  endfunction

  function automatic bit m_redirect();
    return (pc_src_in != 2'b11) || branch_taken_in;
  endfunction

  always @(posedge clk) begin
    if (rst_in) begin
      m_pc      = BOOT;
      m_booting = 1'b1;
      m_parked  = 1'b0;
    end else if (m_booting) begin
      m_booting = 1'b0;
    end else if (ahb_ready_in) begin
      m_pc     = (m_parked && !m_redirect()) ? m_park_addr : m_target();
      m_parked = 1'b0;
    end else if (m_redirect()) begin
      m_parked    = 1'b1;
      m_park_addr = m_target();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] tgt;
      bit          mis;
      tgt = m_target();
      mis = branch_taken_in && (pc_src_in == 2'b11) && tgt[1];
      chk("model_iaddr",    iaddr_a,  m_pc);
      chk("model_pc_mux",   pc_mux_a, tgt);
      chk("model_pc_plus4", pp4_a,    m_pc + 32'd4);
      chk("model_pending",  {31'd0, pend_a}, {31'd0, m_parked});
      chk("model_fvalid",   {31'd0, fv_a},   {31'd0, !m_booting && !m_parked});
      chk("model_misalign", {31'd0, mis_a},  {31'd0, mis});
      chk("model_c_iaddr",  iaddr_c,  m_pc);
      chk("model_c_pend",   {31'd0, pend_c}, {31'd0, m_parked});
      chk("model_c_fvalid", {31'd0, fv_c},   {31'd0, !m_booting && !m_parked});
      chk("model_c_misal",  {31'd0, mis_c},  32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit rdy, input logic [1:0] src, input bit br, input logic [31:0] tgt);
    ahb_ready_in    = rdy;
    pc_src_in       = src;
    branch_taken_in = br;
    iaddr_in        = tgt[31:1];
  endtask

  initial begin
    rst_in          = 1'b1;
    epc_in          = 32'h0000_0200;
    trap_address_in = 32'h0000_0100;
    drive(1'b1, 2'b11, 1'b0, 32'h0);
    @(posedge clk);
    chk_en = 1'b1;
    tick();

    // Reset release and sequential fetch
    chk("rst_iaddr", iaddr_a, 32'h0000_1000);
    chk("rst_fvalid", {31'd0, fv_a}, 32'd0);
    chk("rst_pending", {31'd0, pend_a}, 32'd0);
    rst_in = 1'b0;
    tick();
    chk("bubble_iaddr", iaddr_a, 32'h0000_1000);
    chk("bubble_fvalid", {31'd0, fv_a}, 32'd1);
    tick();
    chk("seq_1004", iaddr_a, 32'h0000_1004);
    tick();
    chk("seq_1008", iaddr_a, 32'h0000_1008);

    // Branch stalled for three cycles
    drive(1'b1, 2'b11, 1'b1, 32'h20);
    tick();
    chk("br_0x20", iaddr_a, 32'h20);
    drive(1'b0, 2'b11, 1'b1, 32'h80);
    tick();
    drive(1'b0, 2'b11, 1'b0, 32'h0);
    tick();
    tick();
    chk("stall_pending", {31'd0, pend_a}, 32'd1);
    chk("stall_fvalid", {31'd0, fv_a}, 32'd0);
    chk("stall_iaddr", iaddr_a, 32'h20);
    drive(1'b1, 2'b11, 1'b0, 32'h0);
    tick();
    chk("release_0x80", iaddr_a, 32'h80);
    chk("release_pending", {31'd0, pend_a}, 32'd0);

    // Trap overrides a parked branch
    drive(1'b0, 2'b11, 1'b1, 32'h80);
    tick();
    drive(1'b0, 2'b10, 1'b0, 32'h0);
    tick();
    drive(1'b1, 2'b11, 1'b0, 32'h0);
    tick();
    chk("latest_wins_0x100", iaddr_a, 32'h100);

    // Redirect arriving in the release cycle beats the parked one
    drive(1'b0, 2'b11, 1'b1, 32'h80);
    tick();
    epc_in = 32'h0000_0300;
    drive(1'b1, 2'b01, 1'b0, 32'h0);
    tick();
    chk("release_redirect_0x300", iaddr_a, 32'h300);

    // Boot selection while running
    drive(1'b1, 2'b00, 1'b0, 32'h0);
    tick();
    chk("boot_sel", iaddr_a, 32'h0000_1000);

    // Misaligned branch target
    drive(1'b1, 2'b11, 1'b1, 32'h82);
    #1;
    chk("misal_c0", {31'd0, mis_a}, 32'd1);
    chk("misal_c1", {31'd0, mis_c}, 32'd0);
    tick();
    chk("misal_load_c0", iaddr_a, 32'h82);
    chk("misal_load_c1", iaddr_c, 32'h82);

    // Wrap at the top of the address space
    drive(1'b1, 2'b11, 1'b1, 32'hFFFF_FFFC);
    tick();
    chk("top_addr", iaddr_a, 32'hFFFF_FFFC);
    drive(1'b1, 2'b11, 1'b0, 32'h0);
    #1;
    chk("wrap_pp4", pp4_a, 32'h0);
    tick();
    chk("wrap_iaddr", iaddr_a, 32'h0);

    // Reset while a redirect is parked
    drive(1'b0, 2'b11, 1'b1, 32'h80);
    tick();
    chk("hold_before_rst", {31'd0, pend_a}, 32'd1);
    rst_in = 1'b1;
    drive(1'b1, 2'b11, 1'b0, 32'h0);
    tick();
    chk("rst_hold_iaddr", iaddr_a, 32'h0000_1000);
    chk("rst_hold_pending", {31'd0, pend_a}, 32'd0);
    chk("rst_hold_fvalid", {31'd0, fv_a}, 32'd0);
    rst_in = 1'b0;
    tick();
    chk("post_rst_bubble", iaddr_a, 32'h0000_1000);
    tick();
    chk("post_rst_seq", iaddr_a, 32'h0000_1004);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
